// File: rtl/ibex_hpm_counter_bank_pkg.sv
// Shared constants, CSR numbers and address decode for the HPM counter bank.
package ibex_hpm_counter_bank_pkg;

  localparam int unsigned MHPM_FIRST_IDX    = 3;
  localparam int unsigned MHPM_MAX_COUNTERS = 29;

  localparam logic [11:0] CSR_OFF_MHPMEVENT    = 12'h320;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MHPMCOUNTERH = 12'hB80;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT  = 12'h320,
    CSR_MHPMEVENT3     = 12'h323,
    CSR_MHPMEVENT4     = 12'h324,
    CSR_MHPMCOUNTER3   = 12'hB03,
    CSR_MHPMCOUNTER4   = 12'hB04,
    CSR_MHPMCOUNTER3H  = 12'hB83
  } csr_num_e;

  typedef enum logic [2:0] {
    HpmNone,
    HpmInhibit,
    HpmEvent,
    HpmCntLo,
    HpmCntHi
  } hpm_region_e;

  // Indices 0..2 of each 32-entry window belong to mcycle/minstret and are not ours.
  function automatic hpm_region_e hpm_decode(logic [11:0] addr);
    hpm_region_e region;
    region = HpmNone;
    if (addr == CSR_OFF_MHPMEVENT) begin
      region = HpmInhibit;
    end else if (addr[4:0] >= 5'(MHPM_FIRST_IDX)) begin
      case (addr[11:5])
        CSR_OFF_MHPMEVENT[11:5]:    region = HpmEvent;
        CSR_OFF_MHPMCOUNTER[11:5]:  region = HpmCntLo;
        CSR_OFF_MHPMCOUNTERH[11:5]: region = HpmCntHi;
        default:                    region = HpmNone;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/ibex_hpm_counter.sv
// One HPM counter with its event mask and sticky wrap flag.
module ibex_hpm_counter #(
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumEvents-1:0] events_i,
  input  logic                 count_en_i,
  input  logic                 event_we_i,
  input  logic                 cnt_we_lo_i,
  input  logic                 cnt_we_hi_i,
  input  logic [31:0]          wdata_i,
  output logic [NumEvents-1:0] event_o,
  output logic [63:0]          counter_o,
  output logic                 overflow_o
);

  logic [NumEvents-1:0]    event_q, event_d;
  logic [CounterWidth-1:0] counter_q, counter_d;
  logic                    overflow_q, overflow_d;
  logic                    inc;
  logic [63:0]             cnt_wr;

  assign inc = (|(events_i & event_q)) & count_en_i;

  always_comb begin
    event_d    = event_q;
    counter_d  = counter_q;
    overflow_d = overflow_q;
    cnt_wr     = 64'(counter_q);
    if (event_we_i) begin
      event_d = wdata_i[NumEvents-1:0];
    end
    // Truncation to CounterWidth drops high-half writes for narrow counters.
    if (cnt_we_lo_i || cnt_we_hi_i) begin
      if (cnt_we_lo_i) cnt_wr[31:0]  = wdata_i;
      if (cnt_we_hi_i) cnt_wr[63:32] = wdata_i;
      counter_d  = cnt_wr[CounterWidth-1:0];
      overflow_d = 1'b0;
    end else if (inc) begin
      counter_d = counter_q + CounterWidth'(1);
      if (&counter_q) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      event_q    <= '0;
      counter_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      event_q    <= event_d;
      counter_q  <= counter_d;
      overflow_q <= overflow_d;
    end
  end

  assign event_o    = event_q;
  assign counter_o  = 64'(counter_q);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Bank of mhpmcounter/mhpmevent registers plus mcountinhibit[31:3], with CSR decode and read mux.
module ibex_hpm_counter_bank
  import ibex_hpm_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumEvents-1:0]   events_i,
  input  logic                   debug_mode_i,
  input  logic                   stopcount_i,
  input  logic [11:0]            csr_addr_i,
  input  logic                   csr_we_i,
  input  logic [31:0]            csr_wdata_i,
  output logic                   csr_hit_o,
  output logic [31:0]            csr_rdata_o,
  output logic [NumCounters-1:0] overflow_o
);

  hpm_region_e            region;
  logic [NumCounters-1:0] inhibit_q, inhibit_d;
  logic                   stop_all;
  logic [NumEvents-1:0]   event_val [NumCounters];
  logic [63:0]            cnt_val   [NumCounters];

  assign region    = hpm_decode(csr_addr_i);
  assign csr_hit_o = (region != HpmNone);
  assign stop_all  = debug_mode_i & stopcount_i;

  // inhibit_q[k] holds mcountinhibit[k+3].
  always_comb begin
    inhibit_d = inhibit_q;
    if (csr_we_i && region == HpmInhibit) begin
      inhibit_d = csr_wdata_i[NumCounters+MHPM_FIRST_IDX-1:MHPM_FIRST_IDX];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q <= '0;
    end else begin
      inhibit_q <= inhibit_d;
    end
  end

  for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
    logic sel_we;
    assign sel_we = csr_we_i && (csr_addr_i[4:0] == 5'(k + MHPM_FIRST_IDX));

    ibex_hpm_counter #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .events_i    (events_i),
      .count_en_i  (~inhibit_q[k] & ~stop_all),
      .event_we_i  (sel_we && region == HpmEvent),
      .cnt_we_lo_i (sel_we && region == HpmCntLo),
      .cnt_we_hi_i (sel_we && region == HpmCntHi),
      .wdata_i     (csr_wdata_i),
      .event_o     (event_val[k]),
      .counter_o   (cnt_val[k]),
      .overflow_o  (overflow_o[k])
    );
  end

  // Unimplemented indices fall through the loop and read 0.
  always_comb begin
    csr_rdata_o = '0;
    if (region == HpmInhibit) begin
      csr_rdata_o = 32'(inhibit_q) << MHPM_FIRST_IDX;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        if (csr_addr_i[4:0] == 5'(i + MHPM_FIRST_IDX)) begin
          case (region)
            HpmEvent: csr_rdata_o = 32'(event_val[i]);
            HpmCntLo: csr_rdata_o = cnt_val[i][31:0];
            HpmCntHi: csr_rdata_o = cnt_val[i][63:32];
            default:  csr_rdata_o = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Scoreboard bench for ibex_hpm_counter_bank with default parameters (8 x 40-bit, 16 events).
module tb_ibex_hpm_counter_bank;
  import ibex_hpm_counter_bank_pkg::*;

  localparam int unsigned NumCounters  = 8;
  localparam int unsigned CounterWidth = 40;
  localparam int unsigned NumEvents    = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumEvents-1:0]   events_i;
  logic                   debug_mode_i;
  logic                   stopcount_i;
  logic [11:0]            csr_addr_i;
  logic                   csr_we_i;
  logic [31:0]            csr_wdata_i;
  logic                   csr_hit_o;
  logic [31:0]            csr_rdata_o;
  logic [NumCounters-1:0] overflow_o;

  ibex_hpm_counter_bank #(
    .NumCounters  (NumCounters),
    .CounterWidth (CounterWidth),
    .NumEvents    (NumEvents)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .events_i     (events_i),
    .debug_mode_i (debug_mode_i),
    .stopcount_i  (stopcount_i),
    .csr_addr_i   (csr_addr_i),
    .csr_we_i     (csr_we_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_hit_o    (csr_hit_o),
    .csr_rdata_o  (csr_rdata_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive address now, compare once the combinational read has settled.
  task automatic sample(input logic [11:0] addr, input logic [31:0] rdata, input logic hit,
                        input string tag);
    exp_t e;
    csr_addr_i = addr;
    sb_q.push_back('{tag: tag, rdata: rdata, hit: hit});
    #1;
    e = sb_q.pop_front();
    check_val({e.tag, ".rdata"}, 64'(csr_rdata_o), 64'(e.rdata));
    check_val({e.tag, ".hit"}, 64'(csr_hit_o), 64'(e.hit));
  endtask

  task automatic csr_read(input logic [11:0] addr, input logic [31:0] rdata, input logic hit,
                          input string tag);
    @(negedge clk_i);
    sample(addr, rdata, hit, tag);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    csr_addr_i  = addr;
    csr_wdata_i = data;
    csr_we_i    = 1'b1;
    @(negedge clk_i);
    csr_we_i    = 1'b0;
  endtask

  task automatic run_events(input logic [NumEvents-1:0] ev, input int cycles);
    @(negedge clk_i);
    events_i = ev;
    repeat (cycles) @(negedge clk_i);
    events_i = '0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    events_i     = '0;
    debug_mode_i = 1'b0;
    stopcount_i  = 1'b0;
    csr_addr_i   = '0;
    csr_we_i     = 1'b0;
    csr_wdata_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset state
    csr_read(12'hB03, 32'h0, 1'b1, "rst_cnt3_lo");
    csr_read(12'hB83, 32'h0, 1'b1, "rst_cnt3_hi");
    csr_read(12'h323, 32'h0, 1'b1, "rst_evt3");
    csr_read(12'h320, 32'h0, 1'b1, "rst_inhibit");
    check_val("rst_overflow", 64'(overflow_o), 64'h0);

    // Event mask selection; both selected bits high still counts once per cycle
    csr_write(CSR_MHPMEVENT3, 32'h0000_0005);
    csr_read(CSR_MHPMEVENT3, 32'h5, 1'b1, "evt3_rb");
    run_events(16'h0005, 10);
    run_events(16'h0002, 5);
    csr_read(CSR_MHPMCOUNTER3, 32'd10, 1'b1, "cnt3_masked");

    // High-half write keeps low bits, then wrap from all-ones
    csr_write(CSR_MHPMCOUNTER3H, 32'h0000_00FF);
    csr_read(CSR_MHPMCOUNTER3, 32'd10, 1'b1, "hi_wr_keeps_lo");
    csr_write(CSR_MHPMCOUNTER3, 32'hFFFF_FFFF);
    csr_read(CSR_MHPMCOUNTER3H, 32'hFF, 1'b1, "lo_wr_keeps_hi");
    check_val("ovf_before_wrap", 64'(overflow_o), 64'h0);
    run_events(16'h0001, 1);
    csr_read(CSR_MHPMCOUNTER3, 32'h0, 1'b1, "wrap_lo");
    csr_read(CSR_MHPMCOUNTER3H, 32'h0, 1'b1, "wrap_hi");
    check_val("ovf_after_wrap", 64'(overflow_o), 64'h1);
    csr_write(CSR_MHPMCOUNTER3, 32'h0);
    check_val("ovf_cleared", 64'(overflow_o), 64'h0);

    // Write wins over a same-cycle increment
    @(negedge clk_i);
    events_i    = 16'h0001;
    csr_addr_i  = CSR_MHPMCOUNTER3;
    csr_wdata_i = 32'h0000_1234;
    csr_we_i    = 1'b1;
    @(negedge clk_i);
    csr_we_i = 1'b0;
    events_i = '0;
    csr_read(CSR_MHPMCOUNTER3, 32'h1234, 1'b1, "write_priority");

    // Inhibit counter3 only
    csr_write(CSR_MHPMEVENT4, 32'h0000_0001);
    csr_write(CSR_MCOUNTINHIBIT, 32'h0000_0008);
    csr_read(CSR_MCOUNTINHIBIT, 32'h8, 1'b1, "inhibit_rb");
    run_events(16'h0001, 6);
    csr_read(CSR_MHPMCOUNTER3, 32'h1234, 1'b1, "inhibit_cnt3");
    csr_read(CSR_MHPMCOUNTER4, 32'd6, 1'b1, "inhibit_cnt4");
    csr_write(CSR_MCOUNTINHIBIT, 32'h0);

    // Debug stop-count freezes everything; debug alone does not
    debug_mode_i = 1'b1;
    stopcount_i  = 1'b1;
    run_events(16'h0001, 4);
    csr_read(CSR_MHPMCOUNTER3, 32'h1234, 1'b1, "stop_cnt3");
    csr_read(CSR_MHPMCOUNTER4, 32'd6, 1'b1, "stop_cnt4");
    stopcount_i = 1'b0;
    run_events(16'h0001, 2);
    csr_read(CSR_MHPMCOUNTER3, 32'h1236, 1'b1, "dbg_cnt3");
    csr_read(CSR_MHPMCOUNTER4, 32'd8, 1'b1, "dbg_cnt4");
    debug_mode_i = 1'b0;

    // Field widths on write
    csr_write(12'h325, 32'hFFFF_FFFF);
    csr_read(12'h325, 32'h0000_FFFF, 1'b1, "evt5_width");
    csr_write(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    csr_read(CSR_MCOUNTINHIBIT, 32'h0000_07F8, 1'b1, "inhibit_width");
    csr_write(CSR_MCOUNTINHIBIT, 32'h0);

    // Unimplemented indices and out-of-range addresses
    csr_write(12'hB0B, 32'hDEAD_BEEF);
    csr_write(12'h32B, 32'hDEAD_BEEF);
    csr_write(12'hB8B, 32'hDEAD_BEEF);
    csr_read(12'hB0B, 32'h0, 1'b1, "unimpl_lo");
    csr_read(12'h32B, 32'h0, 1'b1, "unimpl_evt");
    csr_read(12'hB8B, 32'h0, 1'b1, "unimpl_hi");
    csr_read(12'hB9F, 32'h0, 1'b1, "top_hi");
    csr_read(12'hB00, 32'h0, 1'b0, "miss_b00");
    csr_read(12'h321, 32'h0, 1'b0, "miss_321");
    csr_read(12'h340, 32'h0, 1'b0, "miss_340");
    csr_read(12'hB0A, 32'h0, 1'b1, "cnt10_untouched");

    // Asynchronous reset mid-count
    csr_write(CSR_MHPMCOUNTER3, 32'd54);
    @(negedge clk_i);
    events_i = 16'h0001;
    repeat (3) @(negedge clk_i);
    sample(CSR_MHPMCOUNTER3, 32'd57, 1'b1, "pre_reset_cnt3");
    rst_ni = 1'b0;
    sample(CSR_MHPMCOUNTER3, 32'h0, 1'b1, "async_reset_cnt3");
    sample(CSR_MHPMEVENT3, 32'h0, 1'b1, "async_reset_evt3");
    @(negedge clk_i);
    rst_ni   = 1'b1;
    events_i = '0;
    csr_read(CSR_MHPMCOUNTER4, 32'h0, 1'b1, "post_reset_cnt4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_hpm_counter_bank.md
Name: ibex_hpm_counter_bank

Overview:
Parametrised bank of RISC-V machine hardware performance-monitor counters (mhpmcounter3..N, mhpmevent3..N, mcountinhibit[31:3]) with its own CSR decode and read mux. It sits beside ibex_cs_registers; mcycle and minstret stay there. Over a fixed-function counter pair it adds configurable counter count and width, per-counter event-mask selection, debug stop-count, and sticky per-counter overflow flags for future overflow interrupts.

Parameters:
NumCounters, 8, number of implemented counters (1..29), mapped to indices 3..NumCounters+2
CounterWidth, 40, counter width in bits (1..64); unimplemented upper bits read 0
NumEvents, 16, width of event bus and of each mhpmevent mask (1..32)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
events_i  input  NumEvents  per-cycle event pulses from core, one bit per event
debug_mode_i  input  1  core is in debug mode
stopcount_i  input  1  dcsr.stopcount
csr_addr_i  input  12  CSR address
csr_we_i  input  1  CSR write strobe, already qualified (privilege, legality)
csr_wdata_i  input  32  CSR write data
csr_hit_o  output  1  csr_addr_i lies in this block's address space
csr_rdata_o  output  32  CSR read data, combinational
overflow_o  output  NumCounters  sticky wrap flag per counter

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: all counters 0, all mhpmevent 0, mcountinhibit[31:3] 0, overflow_o 0.
- Address space, driving csr_hit_o=1: 0x320, 0x323-0x33F, 0xB03-0xB1F, 0xB83-0xB9F. Every other address gives hit=0 and rdata=0.
- Counters and event registers with index >= NumCounters+3 are hardwired 0: reads return 0, writes are ignored, hit stays 1.
- Reads are combinational in the same cycle; writes take effect on the next clk_i edge.
- Read 0x320: bits [NumCounters+2:3] = inhibit, all other bits 0.
- Read 0x323+k: mhpmevent[k] zero-extended to 32 bits.
- Read 0xB03+k: counter[k][31:0].
- Read 0xB83+k: counter[k][63:32], bits at or above CounterWidth read 0. When CounterWidth <= 32 this read returns 0.
- Increment condition for counter k: inc_k = |(events_i & mhpmevent[k]) & ~inhibit[k+3] & ~(debug_mode_i & stopcount_i).
- An increment adds exactly +1 per cycle, even if several selected events fire in that cycle.
- Wrap: an increment from all-ones (CounterWidth bits) gives 0 and sets overflow_o[k] on the next cycle. The flag holds until any write to 0xB03+k or 0xB83+k.
- Write to the low half: counter[k][31:0] <= wdata, and the upper bits are kept.
- Write to the high half: counter[k][CounterWidth-1:32] <= wdata[CounterWidth-33:0], and the low bits are kept. Ignored when CounterWidth <= 32.
- Write priority: a counter written in a cycle does not increment in that cycle, and the written value is stored exactly.
- Write and wrap in the same cycle: the write wins and overflow_o[k] is cleared.
- Write to mhpmevent[k]: stores wdata[NumEvents-1:0].
- Write to 0x320: stores bits [NumCounters+2:3]; bits [2:0] and bits above NumCounters+2 are ignored.
- An inhibit or stopcount change takes effect on the increment in the same cycle its register value is visible; a write to inhibit blocks counting from the following cycle.
- Reset asserted mid-count clears all state immediately (asynchronous); counting resumes on the first edge after deassertion.

Decomposition:
- ibex_pkg gains:
  - MHPM_FIRST_IDX = 3
  - MHPM_MAX_COUNTERS = 29
  - CSR_OFF_MHPMEVENT = 12'h320, CSR_OFF_MHPMCOUNTER = 12'hB00, CSR_OFF_MHPMCOUNTERH = 12'hB80
- The existing csr_num_e entries are reused.
- Sub-module ibex_hpm_counter: one counter, its event mask, and its overflow flag, parametrised by CounterWidth and NumEvents. Instantiated NumCounters times via generate.

Test Plan:
- Reset, then read 0xB03, 0xB83, 0x323, 0x320 -> all 0; overflow_o=0; csr_hit_o=1 for each.
- Write mhpmevent3=0x0005, pulse events_i=0x0005 for 10 cycles and 0x0002 for 5 cycles -> counter3 reads 10; a cycle with both selected bits high counts 1.
- CounterWidth=40: write 0xB83=0xFF, then 0xB03=0xFFFFFFFF, then one selected event -> counter reads 0, overflow_o[0]=1 next cycle; write 0xB03=0 -> overflow_o[0]=0.
- Write 0xB03=0x1234 in a cycle with a selected event -> reads exactly 0x1234. Write 0x320=0x8 -> counter3 frozen while counter4 keeps counting. debug_mode_i=stopcount_i=1 -> all counters frozen.
- NumCounters=8: write/read 0xB0B, 0x32B, 0xB8B -> read 0, hit=1. Address 0xB00 and 0x321 -> hit=0, rdata=0.
- Assert rst_ni low for half a cycle mid-count with counter3=57 -> counter3 reads 0 immediately, before the next edge.
